// File: rtl/wb_pkg.sv
// Shared definitions for the two-master Wishbone arbiter: FSM encoding,
// slave address window bounds and master indices.
package wb_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_OWN  = 2'd1;
  localparam state_t ST_ERR  = 2'd2;

  // Slave window 0x2000-0x5FFF, decoded on ADR[14:12] only
  localparam logic [2:0] WIN_LO = 3'b010;
  localparam logic [2:0] WIN_HI = 3'b101;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  function automatic logic in_window(input logic [2:0] sel);
    return (sel >= WIN_LO) && (sel <= WIN_HI);
  endfunction

endpackage

// File: rtl/wb_timeout_timer.sv
// Stall counter: counts enabled cycles and flags the cycle on which the
// TIMEOUT-th consecutive stall cycle occurs.
module wb_timeout_timer #(
  parameter int TW      = 8,
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] cnt_r;

  // Stall cycle counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (en) begin
      cnt_r <= cnt_r + TW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expired = en & (cnt_r == LAST);

endmodule

// File: rtl/wb_bus_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of one slave; the grant is
// held for a whole CYC, and unmapped or stalled strobes are ended with ERR.
module wb_bus_arbiter
  import wb_pkg::*;
#(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input  logic          CLK_I,
  input  logic          RST_I,
  input  logic          M0_CYC_I,
  input  logic          M0_STB_I,
  input  logic          M0_WE_I,
  input  logic [AW-1:0] M0_ADR_I,
  input  logic [DW-1:0] M0_DAT_I,
  output logic [DW-1:0] M0_DAT_O,
  output logic          M0_ACK_O,
  output logic          M0_ERR_O,
  input  logic          M1_CYC_I,
  input  logic          M1_STB_I,
  input  logic          M1_WE_I,
  input  logic [AW-1:0] M1_ADR_I,
  input  logic [DW-1:0] M1_DAT_I,
  output logic [DW-1:0] M1_DAT_O,
  output logic          M1_ACK_O,
  output logic          M1_ERR_O,
  output logic          S_CYC_O,
  output logic          S_STB_O,
  output logic          S_WE_O,
  output logic [AW-1:0] S_ADR_O,
  output logic [DW-1:0] S_DAT_O,
  input  logic [DW-1:0] S_DAT_I,
  input  logic          S_ACK_I,
  output logic [1:0]    GNT_O
);

  state_t     state_r, state_nxt_s;
  logic       owner_r, owner_nxt_s;
  logic       last_gnt_r, last_nxt_s;
  logic [1:0] gnt_r, gnt_nxt_s;

  logic          own_cyc_s, own_stb_s, own_we_s;
  logic [AW-1:0] own_adr_s;
  logic [DW-1:0] own_dat_s;
  logic          req0_s, req1_s, pick_s;
  logic          active_s, in_win_s, stb_s, ack_s, err_s;
  logic          tmr_clr_s, tmr_en_s, expired_s;

  // Owner signal mux
  always_comb begin
    if (owner_r == M1) begin
      own_cyc_s = M1_CYC_I;
      own_stb_s = M1_STB_I;
      own_we_s  = M1_WE_I;
      own_adr_s = M1_ADR_I;
      own_dat_s = M1_DAT_I;
    end else begin
      own_cyc_s = M0_CYC_I;
      own_stb_s = M0_STB_I;
      own_we_s  = M0_WE_I;
      own_adr_s = M0_ADR_I;
      own_dat_s = M0_DAT_I;
    end
  end

  // Request qualification and round-robin pick on a tie
  always_comb begin
    req0_s = M0_CYC_I & M0_STB_I;
    req1_s = M1_CYC_I & M1_STB_I;
    if (req0_s & req1_s) begin
      pick_s = ~last_gnt_r;
    end else if (req1_s) begin
      pick_s = M1;
    end else begin
      pick_s = M0;
    end
  end

  assign active_s  = (state_r == ST_OWN) || (state_r == ST_ERR);
  assign in_win_s  = in_window(own_adr_s[14:12]);
  assign stb_s     = (state_r == ST_OWN) & own_stb_s & in_win_s;
  assign ack_s     = stb_s & S_ACK_I;
  assign err_s     = (state_r == ST_ERR);
  assign tmr_en_s  = stb_s & ~S_ACK_I;
  assign tmr_clr_s = (state_r != ST_OWN) | ~stb_s | S_ACK_I;

  wb_timeout_timer #(
    .TW      (TW),
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (CLK_I),
    .rst     (RST_I),
    .clr     (tmr_clr_s),
    .en      (tmr_en_s),
    .expired (expired_s)
  );

  // Arbitration FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    owner_nxt_s = owner_r;
    last_nxt_s  = last_gnt_r;
    gnt_nxt_s   = gnt_r;
    case (state_r)
      ST_IDLE: begin
        if (req0_s | req1_s) begin
          owner_nxt_s = pick_s;
          gnt_nxt_s   = (pick_s == M1) ? 2'b10 : 2'b01;
          state_nxt_s = ST_OWN;
        end else begin
          gnt_nxt_s   = 2'b00;
        end
      end
      ST_OWN: begin
        if (!own_cyc_s) begin
          state_nxt_s = ST_IDLE;
          last_nxt_s  = owner_r;
          gnt_nxt_s   = 2'b00;
        end else if ((own_stb_s & ~in_win_s) | expired_s) begin
          state_nxt_s = ST_ERR;
        end else begin
          state_nxt_s = ST_OWN;
        end
      end
      ST_ERR: begin
        if (!own_cyc_s) begin
          state_nxt_s = ST_IDLE;
          last_nxt_s  = owner_r;
          gnt_nxt_s   = 2'b00;
        end else begin
          state_nxt_s = ST_OWN;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        gnt_nxt_s   = 2'b00;
      end
    endcase
  end

  // FSM and grant registers
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_r    <= ST_IDLE;
      owner_r    <= M0;
      last_gnt_r <= M1;
      gnt_r      <= 2'b00;
    end else begin
      state_r    <= state_nxt_s;
      owner_r    <= owner_nxt_s;
      last_gnt_r <= last_nxt_s;
      gnt_r      <= gnt_nxt_s;
    end
  end

  assign S_CYC_O  = active_s;
  assign S_STB_O  = stb_s;
  assign S_WE_O   = active_s & own_we_s;
  assign S_ADR_O  = active_s ? own_adr_s : '0;
  assign S_DAT_O  = active_s ? own_dat_s : '0;
  assign GNT_O    = gnt_r;

  // Read data is broadcast; held at zero while reset is asserted
  assign M0_DAT_O = RST_I ? '0 : S_DAT_I;
  assign M1_DAT_O = RST_I ? '0 : S_DAT_I;
  assign M0_ACK_O = ack_s & (owner_r == M0);
  assign M1_ACK_O = ack_s & (owner_r == M1);
  assign M0_ERR_O = err_s & (owner_r == M0);
  assign M1_ERR_O = err_s & (owner_r == M1);

endmodule
